irq_controller: RTL and testbench
=================================

Name: irq_controller

Overview:
- Interrupt controller directly upstream of the CPU core.
- Collects up to NSRC external interrupt sources, synchronises them and edge-detects them into pending bits, then applies a mask and a fixed priority.
- Drives the core's irq, intAddr and intData inputs, and consumes its turnOffIRQ acknowledge.
- Exposes a small memory-mapped register window on the core's memory bus; the system bus mux returns rdata when sel is high.

Parameters:
- M, 16, data bus width.
- N, 32, address bus width.
- NSRC, 8, number of interrupt sources (1..8).
- BASE, 32'hE000_0000, bus address of register 0; the window is 4 words.
- VEC_SHIFT, 2, log2 of the vector-table slot size in words.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- src  in  NSRC  asynchronous interrupt lines; a rising edge requests an interrupt.
- irq  out  1  interrupt request to the core.
- intAddr  out  N  handler address for the presented source.
- intData  out  M  cause word for the presented source.
- turnOffIRQ  in  1  acknowledge from the core.
- memAddr  in  N  bus address.
- memWrite  in  M  bus write data.
- memWE  in  1  bus write enable.
- memRE  in  1  bus read enable.
- sel  out  1  memAddr falls inside the window; combinational.
- rdata  out  M  read data; combinational, 0 when sel is low.

Behaviour:
- Reset values:
  - irq = 0; intAddr = 0; intData = 0.
  - mask = 0 (all disabled); pending = 0.
  - vecLo = 0; vecHi = 0.
  - Synchroniser and edge-detect flops = 0; FSM in IDLE.
- Register map (word offset = memAddr - BASE):
  - 0: MASK (R/W). Bits [NSRC-1:0] are active; other bits read 0.
  - 1: PENDING. Reads return pending. Writing 1 to a bit clears it (W1C).
  - 2: VECLO (R/W).
  - 3: VECHI (R/W).
- Register writes take effect at the clock edge where memWE is high and sel is high.
- Input path: 2-flop synchroniser per source, then a prev flop. A rising edge is sync2 & ~prev.
  - If src first reads high at edge k, pending sets at edge k+2.
  - irq is asserted after edge k+3 when the source is unmasked and the FSM is idle.
- Eligible set = pending & mask. The winner is the lowest-index eligible bit.
- FSM states:
  - IDLE: irq = 0. If any source is eligible, go to PRESENT at the next edge. At that edge latch:
    - idx = winner.
    - intAddr = {vecHi, vecLo} + (idx << VEC_SHIFT), modulo 2^N.
    - intData = {pending snapshot zero-extended to 8 bits, 5'b0, idx[2:0]}.
  - PRESENT: irq = 1.
    - intAddr, intData and idx are frozen, even if mask, pending or vector registers change.
    - On an edge with turnOffIRQ = 1: clear pending[idx] and go to ACK.
  - ACK: irq = 0. Go to IDLE unconditionally at the next edge.
  - Consequence: irq is low for at least 2 cycles between back-to-back interrupts.
- intAddr and intData hold their last latched values outside PRESENT.
- turnOffIRQ is ignored in IDLE and ACK.
- Simultaneous events:
  - A new edge on source idx in the same cycle as its ack or W1C clear: set wins, and the bit stays pending.
  - A W1C on pending[idx] while in PRESENT has no effect on that bit; the ack clears it. W1C on other bits applies normally.
  - Masking the presented source while in PRESENT does not retract irq.
- An edge on an already-pending source is absorbed; there is no counting.
- A synchronous reset mid-PRESENT drops irq at the next edge and discards all pending state.
- memRE has no side effects. The PENDING read is not clear-on-read.

Decomposition:
- Shared package/constants file: register offsets (REG_MASK, REG_PEND, REG_VECLO, REG_VECHI) and FSM state encodings (IDLE, PRESENT, ACK), alongside the existing CPU constants.
- One natural sub-module: irq_sync_edge. It is per-bit and NSRC wide, contains the 2-flop synchroniser and prev flop, and outputs rise pulses.
- Registers use the existing register primitive where convenient.

Test Plan:
- Reset, then read offsets 0..3 via memAddr = BASE+0..3 -> rdata = 0, 0, 0, 0; sel = 1. Read BASE+4 -> sel = 0, rdata = 0.
- Setup: VECHI = 16'h0001, VECLO = 16'h0100, MASK = 8'h08. Pulse src[3] high for 1 cycle -> irq rises 4 edges later; intAddr = 32'h0001_010C; intData = 16'h0803.
- In PRESENT, drive turnOffIRQ for 1 cycle -> irq = 0 next cycle, PENDING reads 0, FSM passes through ACK to IDLE with irq low for 2 cycles.
- Priority: MASK = 8'hFF, raise src[5] and src[2] on the same edge -> first present idx 2, intData = 16'h2402. After ack, idx 5 is presented, intData = 16'h2005, intAddr = base + 20.
- Masked source: MASK = 0, edge on src[1] -> PENDING = 8'h02, irq stays 0. Write MASK = 8'h02 -> irq asserts. Write 1 to PENDING bit 1 while presenting -> irq stays 1 until ack.
- Set-wins and reset: edge on src[4] lands in the ack cycle of idx 4 -> bit 4 is re-presented after ACK/IDLE. Assert rst mid-PRESENT -> irq = 0 and PENDING = 0 next cycle.

Source files
------------

// File: rtl/irq_controller_pkg.sv
// rtl/irq_controller_pkg.sv - shared CPU constants, register offsets and FSM encodings for irq_controller
//
// Contents:
//   CPU_M / CPU_N     default data / address bus widths of the core
//   REG_*             word offsets inside the controller register window
//   irq_state_t       presentation FSM states
//   lowest_set()      fixed-priority encoder (lowest index wins)
package irq_controller_pkg;

    localparam int CPU_M = 16;
    localparam int CPU_N = 32;

    localparam logic [1:0] REG_MASK  = 2'd0;
    localparam logic [1:0] REG_PEND  = 2'd1;
    localparam logic [1:0] REG_VECLO = 2'd2;
    localparam logic [1:0] REG_VECHI = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        ACK     = 2'd2
    } irq_state_t;

    // Scan from the top down so the last hit, i.e. the lowest set bit, is kept.
    function automatic logic [2:0] lowest_set(input logic [7:0] v);
        lowest_set = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                lowest_set = 3'(i);
            end
        end
    endfunction

endpackage

// File: rtl/irq_controller_if.sv
// rtl/irq_controller_if.sv - core memory-bus view of the irq_controller register window
//
// Signals:
//   memAddr   bus address            (master -> slave)
//   memWrite  bus write data         (master -> slave)
//   memWE     write enable           (master -> slave)
//   memRE     read enable            (master -> slave)
//   sel       address hits window    (slave -> master, combinational)
//   rdata     read data, 0 if !sel   (slave -> master, combinational)
import irq_controller_pkg::*;

interface irq_controller_if #(
    parameter int M = CPU_M,
    parameter int N = CPU_N
);
    logic [N-1:0] memAddr;
    logic [M-1:0] memWrite;
    logic         memWE;
    logic         memRE;
    logic         sel;
    logic [M-1:0] rdata;

    modport master (
        output memAddr, memWrite, memWE, memRE,
        input  sel, rdata
    );

    modport slave (
        input  memAddr, memWrite, memWE, memRE,
        output sel, rdata
    );
endinterface

// File: rtl/irq_sync_edge.sv
// rtl/irq_sync_edge.sv - per-source 2-flop synchroniser plus rising-edge detector
//
// Ports:
//   clk   clock
//   rst   synchronous active-high reset
//   src   asynchronous interrupt lines
//   rise  one-cycle pulse per synchronised rising edge
import irq_controller_pkg::*;

module irq_sync_edge #(
    parameter int NSRC = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] src,
    output logic [NSRC-1:0] rise
);

    logic [NSRC-1:0] sync1;
    logic [NSRC-1:0] sync2;
    logic [NSRC-1:0] prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= src;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise = sync2 & ~prev;

endmodule

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - masked fixed-priority interrupt controller feeding the CPU core
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   src          asynchronous interrupt lines, rising edge requests
//   irq          interrupt request to the core
//   intAddr      handler address of the presented source
//   intData      cause word {pending snapshot, 5'b0, idx}
//   turnOffIRQ   core acknowledge, honoured only while presenting
//   bus          register window: MASK, PENDING (W1C), VECLO, VECHI
import irq_controller_pkg::*;

module irq_controller #(
    parameter int           M         = CPU_M,
    parameter int           N         = CPU_N,
    parameter int           NSRC      = 8,
    parameter logic [N-1:0] BASE      = 32'hE000_0000,
    parameter int           VEC_SHIFT = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] src,
    output logic            irq,
    output logic [N-1:0]    intAddr,
    output logic [M-1:0]    intData,
    input  logic            turnOffIRQ,
    irq_controller_if.slave bus
);

    irq_state_t      state;
    irq_state_t      state_n;
    logic            load;
    logic            ack;

    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] mask;
    logic [NSRC-1:0] pending;
    logic [NSRC-1:0] pending_n;
    logic [NSRC-1:0] eligible;
    logic [M-1:0]    vec_lo;
    logic [M-1:0]    vec_hi;

    logic [2:0]      idx;
    logic [2:0]      winner;
    logic [NSRC-1:0] idx_bit;
    logic [NSRC-1:0] w1c;
    logic [NSRC-1:0] clr;
    logic [15:0]     cause;

    logic [N-1:0]    offset;
    logic            sel;
    logic            wr;
    logic            unused_re;

    irq_sync_edge #(.NSRC(NSRC)) u_sync_edge (
        .clk  (clk),
        .rst  (rst),
        .src  (src),
        .rise (rise)
    );

    // Unsigned wrap-around makes addresses below BASE land far outside the window.
    assign offset    = bus.memAddr - BASE;
    assign sel       = (offset < N'(4));
    assign bus.sel   = sel;
    assign wr        = bus.memWE & sel;
    // Reads have no side effects, so the read strobe is not needed.
    assign unused_re = bus.memRE;

    always_comb begin
        bus.rdata = '0;
        if (sel) begin
            case (offset[1:0])
                REG_MASK:  bus.rdata = M'(mask);
                REG_PEND:  bus.rdata = M'(pending);
                REG_VECLO: bus.rdata = vec_lo;
                REG_VECHI: bus.rdata = vec_hi;
                default:   bus.rdata = '0;
            endcase
        end
    end

    assign eligible = pending & mask;
    assign winner   = lowest_set(8'(eligible));
    assign idx_bit  = NSRC'(1) << idx;
    assign cause    = {8'(pending), 5'b0, winner};

    // The presented bit is owned by the ack while in PRESENT; software W1C cannot drop it.
    always_comb begin
        w1c = '0;
        if (wr && offset[1:0] == REG_PEND) begin
            w1c = bus.memWrite[NSRC-1:0];
        end
        if (state == PRESENT) begin
            w1c = w1c & ~idx_bit;
        end
    end

    assign clr       = w1c | (ack ? idx_bit : '0);
    // New edges are OR-ed in last so a set always beats a same-cycle clear.
    assign pending_n = (pending & ~clr) | rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            mask    <= '0;
            pending <= '0;
            vec_lo  <= '0;
            vec_hi  <= '0;
        end else begin
            pending <= pending_n;
            if (wr) begin
                case (offset[1:0])
                    REG_MASK:  mask   <= bus.memWrite[NSRC-1:0];
                    REG_VECLO: vec_lo <= bus.memWrite;
                    REG_VECHI: vec_hi <= bus.memWrite;
                    default:   ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            intAddr <= '0;
            intData <= '0;
        end else begin
            state <= state_n;
            if (load) begin
                idx     <= winner;
                intAddr <= N'({vec_hi, vec_lo}) + (N'(winner) << VEC_SHIFT);
                intData <= M'(cause);
            end
        end
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        ack     = 1'b0;
        irq     = 1'b0;
        case (state)
            IDLE: begin
                if (|eligible) begin
                    state_n = PRESENT;
                    load    = 1'b1;
                end
            end
            PRESENT: begin
                irq = 1'b1;
                if (turnOffIRQ) begin
                    ack     = 1'b1;
                    state_n = ACK;
                end
            end
            ACK: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_irq_controller.sv
// tb/tb_irq_controller.sv - directed self-checking bench for irq_controller
module tb_irq_controller;

    localparam int          M    = 16;
    localparam int          N    = 32;
    localparam int          NSRC = 8;
    localparam logic [31:0] BASE = 32'hE000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  src;
    logic        irq;
    logic [31:0] intAddr;
    logic [15:0] intData;
    logic        turnOffIRQ;

    int err_cnt = 0;
    int chk_cnt = 0;

    irq_controller_if #(.M(M), .N(N)) bus ();

    irq_controller #(
        .M(M), .N(N), .NSRC(NSRC), .BASE(BASE), .VEC_SHIFT(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .src        (src),
        .irq        (irq),
        .intAddr    (intAddr),
        .intData    (intData),
        .turnOffIRQ (turnOffIRQ),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_write(input logic [1:0] off, input logic [15:0] d);
        bus.memAddr  = BASE + 32'(off);
        bus.memWrite = d;
        bus.memWE    = 1'b1;
        step();
        bus.memWE    = 1'b0;
        bus.memAddr  = '0;
    endtask

    task automatic reg_check(input string tag, input logic [1:0] off, input logic [15:0] exp);
        bus.memAddr = BASE + 32'(off);
        bus.memRE   = 1'b1;
        #1;
        check(tag, 32'(bus.rdata), 32'(exp));
        bus.memRE   = 1'b0;
        bus.memAddr = '0;
    endtask

    task automatic do_ack();
        turnOffIRQ = 1'b1;
        step();
        turnOffIRQ = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        src          = '0;
        turnOffIRQ   = 1'b0;
        bus.memAddr  = '0;
        bus.memWrite = '0;
        bus.memWE    = 1'b0;
        bus.memRE    = 1'b0;
        step();
        step();
        rst = 1'b0;

        // reset state and window decode
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_intaddr", intAddr, 32'd0);
        check("rst_intdata", 32'(intData), 32'd0);
        for (int i = 0; i < 4; i++) begin
            bus.memAddr = BASE + 32'(i);
            #1;
            check($sformatf("rst_rdata%0d", i), 32'(bus.rdata), 32'd0);
            check($sformatf("rst_sel%0d", i), 32'(bus.sel), 32'd1);
        end
        bus.memAddr = BASE + 32'd4;
        #1;
        check("sel_above", 32'(bus.sel), 32'd0);
        check("rdata_above", 32'(bus.rdata), 32'd0);
        bus.memAddr = BASE - 32'd1;
        #1;
        check("sel_below", 32'(bus.sel), 32'd0);
        bus.memAddr = '0;

        // setup; upper mask bits are not stored
        reg_write(2'd3, 16'h0001);
        reg_write(2'd2, 16'h0100);
        reg_write(2'd0, 16'hFF08);
        reg_check("mask_rb", 2'd0, 16'h0008);
        reg_check("veclo_rb", 2'd2, 16'h0100);
        reg_check("vechi_rb", 2'd3, 16'h0001);

        // single source latency
        src = 8'h08;
        step();
        src = 8'h00;
        check("lat_k0", 32'(irq), 32'd0);
        step();
        reg_check("lat_pend_k1", 2'd1, 16'h0000);
        step();
        reg_check("lat_pend_k2", 2'd1, 16'h0008);
        check("lat_k2", 32'(irq), 32'd0);
        step();
        check("lat_k3", 32'(irq), 32'd1);
        check("s3_intaddr", intAddr, 32'h0001_010C);
        check("s3_intdata", 32'(intData), 32'h0803);

        // acknowledge and ACK/IDLE gap
        do_ack();
        check("ack_irq0", 32'(irq), 32'd0);
        reg_check("ack_pend", 2'd1, 16'h0000);
        step();
        check("ack_irq1", 32'(irq), 32'd0);
        step();
        check("ack_irq2", 32'(irq), 32'd0);

        // priority: src5 and src2 together
        reg_write(2'd0, 16'h00FF);
        src = 8'h24;
        step();
        src = 8'h00;
        step();
        step();
        reg_check("pri_pend", 2'd1, 16'h0024);
        step();
        check("pri_irq_a", 32'(irq), 32'd1);
        check("pri_data_a", 32'(intData), 32'h2402);
        check("pri_addr_a", intAddr, 32'h0001_0108);
        do_ack();
        check("pri_gap0", 32'(irq), 32'd0);
        step();
        check("pri_gap1", 32'(irq), 32'd0);
        step();
        check("pri_irq_b", 32'(irq), 32'd1);
        check("pri_data_b", 32'(intData), 32'h2005);
        check("pri_addr_b", intAddr, 32'h0001_0114);
        do_ack();
        check("hold_addr", intAddr, 32'h0001_0114);
        check("hold_data", 32'(intData), 32'h2005);
        step();
        step();

        // masked sources, late unmask, W1C while presenting
        reg_write(2'd0, 16'h0000);
        src = 8'h42;
        step();
        src = 8'h00;
        step();
        step();
        step();
        check("msk_irq", 32'(irq), 32'd0);
        reg_check("msk_pend", 2'd1, 16'h0042);
        reg_write(2'd0, 16'h0002);
        step();
        check("unmsk_irq", 32'(irq), 32'd1);
        check("unmsk_data", 32'(intData), 32'h4201);
        check("unmsk_addr", intAddr, 32'h0001_0104);
        reg_write(2'd1, 16'h0042);
        check("w1c_irq0", 32'(irq), 32'd1);
        reg_check("w1c_pend", 2'd1, 16'h0002);
        reg_write(2'd0, 16'h0000);
        check("mask_in_present", 32'(irq), 32'd1);
        do_ack();
        reg_check("w1c_ack_pend", 2'd1, 16'h0000);
        step();
        step();

        // set wins over ack clear on the presented bit
        reg_write(2'd0, 16'h0010);
        src = 8'h10;
        step();
        src = 8'h00;
        step();
        step();
        step();
        check("sw_irq", 32'(irq), 32'd1);
        check("sw_data", 32'(intData), 32'h1004);
        check("sw_addr", intAddr, 32'h0001_0110);
        src = 8'h10;
        step();
        src = 8'h00;
        step();
        do_ack();
        check("sw_ack_irq", 32'(irq), 32'd0);
        reg_check("sw_pend", 2'd1, 16'h0010);
        step();
        check("sw_idle_irq", 32'(irq), 32'd0);
        step();
        check("sw_re_irq", 32'(irq), 32'd1);
        check("sw_re_data", 32'(intData), 32'h1004);

        // synchronous reset while presenting
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_irq", 32'(irq), 32'd0);
        reg_check("mid_rst_pend", 2'd1, 16'h0000);
        reg_check("mid_rst_mask", 2'd0, 16'h0000);
        check("mid_rst_addr", intAddr, 32'd0);
        check("mid_rst_data", 32'(intData), 32'd0);
        step();
        check("post_rst_irq", 32'(irq), 32'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
